// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Optional SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/fulladder.sv
// Single-bit full adder cell shared by the serial adder controller.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fulladder cell stepped over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add subtraction (a - b) via the 'sub' request bit.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_sum, fa_cout;
  logic             accept, last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign accept = bus.in_valid && (state_q == ST_IDLE);
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1; the caller's cin is ignored.
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.sum       = '0;
    bus.cout      = 1'b0;
    case (state_q)
      ST_IDLE: bus.in_ready = 1'b1;
      ST_RUN:  bus.busy = 1'b1;
      ST_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.sum       = sum_sh_q;
        bus.cout      = carry_q;
      end
      default: ;
    endcase
  end

  // Result bits enter at the MSB so that after WIDTH steps bit 0 is the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_sh_q  <= bus.a;
      b_sh_q  <= b_load;
      carry_q <= c_load;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
      carry_q  <= fa_cout;
      a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule
